// File: rtl/axis_depacketize.sv
// axis_depacketize
//   Receive-side deframer for a tlast-framed AXI-Stream. Each beat passes
//   through a one-stage register slice and is tagged with first/last. Packets
//   are closed by tlast, by reaching PKT_SIZE beats (oversize), or by running
//   MAX_CLK_CYCLES_PER_PKT-1 cycles since the first beat (timeout). Each close
//   is reported as a one-cycle pkt_done pulse with the length and error flags.
//
//   Optional build macro: AXIS_DEPKT_STATS_EN adds saturating 32-bit packet,
//   oversize and timeout counters.
//
// Ports
//   clk, arstn                 clock, asynchronous active-low reset
//   s_tdata/tvalid/tready/tlast upstream AXI-Stream
//   m_tdata/tvalid/tready      registered downstream AXI-Stream
//   m_tfirst, m_tlast          beat opens / closes its packet
//   pkt_done                   one-cycle close pulse
//   pkt_len                    beats in the closed packet (with pkt_done)
//   pkt_err_oversize/timeout   close reason flags (with pkt_done)
//   stat_pkts/oversize/timeout statistics (AXIS_DEPKT_STATS_EN only)
//
// State  | meaning
// IDLE   | between packets; next accepted beat is first of a packet
// IN_PKT | packet open; counting beats and cycles since first beat

module axis_depacketize #(
    parameter int DATA_WIDTH             = 8,
    parameter int PKT_SIZE               = 4,
    parameter int MAX_CLK_CYCLES_PER_PKT = 10
) (
    input  logic                            clk,
    input  logic                            arstn,
    input  logic [DATA_WIDTH-1:0]           s_tdata,
    input  logic                            s_tvalid,
    output logic                            s_tready,
    input  logic                            s_tlast,
    output logic [DATA_WIDTH-1:0]           m_tdata,
    output logic                            m_tvalid,
    input  logic                            m_tready,
    output logic                            m_tfirst,
    output logic                            m_tlast,
    output logic                            pkt_done,
    output logic [$clog2(PKT_SIZE+1)-1:0]   pkt_len,
    output logic                            pkt_err_oversize,
    output logic                            pkt_err_timeout
`ifdef AXIS_DEPKT_STATS_EN
    ,
    output logic [31:0]                     stat_pkts,
    output logic [31:0]                     stat_oversize,
    output logic [31:0]                     stat_timeout
`endif
);

    localparam int LEN_W = $clog2(PKT_SIZE+1);
    localparam int CNT_W = $clog2(MAX_CLK_CYCLES_PER_PKT+1);
    localparam logic [LEN_W-1:0] PKT_SIZE_L = LEN_W'(PKT_SIZE);
    localparam logic [CNT_W-1:0] CLK_LIMIT  = CNT_W'(MAX_CLK_CYCLES_PER_PKT-1);

    typedef enum logic {IDLE, IN_PKT} state_t;

    state_t           state, state_next;
    logic [LEN_W-1:0] beat_cnt;
    logic [CNT_W-1:0] clk_cnt;
    logic [LEN_W-1:0] beat_cnt_inc;
    logic             accept;
    logic             close_tlast, close_over, close_time, close;

    assign s_tready = !m_tvalid || m_tready;
    assign accept   = s_tvalid && s_tready;

    // Count including the beat being accepted this cycle.
    assign beat_cnt_inc = (state == IDLE) ? LEN_W'(1) : beat_cnt + LEN_W'(1);

    assign close_tlast = accept && s_tlast;
    assign close_over  = accept && !s_tlast && (beat_cnt_inc == PKT_SIZE_L);
    assign close_time  = (state == IN_PKT) && (clk_cnt == CLK_LIMIT);
    assign close       = close_tlast || close_over || close_time;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && !close) state_next = IN_PKT;
            IN_PKT:  if (close)            state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Beat and cycle counters. The cycle counter runs regardless of
    // backpressure, so a long downstream stall can time a packet out.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            beat_cnt <= '0;
            clk_cnt  <= CNT_W'(1);
        end else if (close) begin
            beat_cnt <= '0;
            clk_cnt  <= CNT_W'(1);
        end else if (state == IDLE) begin
            if (accept) begin
                beat_cnt <= LEN_W'(1);
                clk_cnt  <= CNT_W'(1);
            end
        end else begin
            if (accept)              beat_cnt <= beat_cnt_inc;
            if (clk_cnt < CLK_LIMIT) clk_cnt  <= clk_cnt + CNT_W'(1);
        end
    end

    // Register slice. Any close that coincides with an accepted beat makes
    // that beat the last one, so m_tlast simply follows close.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            m_tdata  <= '0;
            m_tvalid <= 1'b0;
            m_tfirst <= 1'b0;
            m_tlast  <= 1'b0;
        end else if (accept) begin
            m_tdata  <= s_tdata;
            m_tvalid <= 1'b1;
            m_tfirst <= (state == IDLE);
            m_tlast  <= close;
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
        end
    end

    // Packet report. Registered alongside the slice so pkt_done coincides
    // with the final beat's first cycle on m_*.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            pkt_done         <= 1'b0;
            pkt_len          <= '0;
            pkt_err_oversize <= 1'b0;
            pkt_err_timeout  <= 1'b0;
        end else begin
            pkt_done <= close;
            if (close) begin
                pkt_len          <= accept ? beat_cnt_inc : beat_cnt;
                pkt_err_oversize <= close_over;
                pkt_err_timeout  <= close_time;
            end
        end
    end

`ifdef AXIS_DEPKT_STATS_EN
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            stat_pkts     <= '0;
            stat_oversize <= '0;
            stat_timeout  <= '0;
        end else if (pkt_done) begin
            if (stat_pkts != '1)
                stat_pkts <= stat_pkts + 32'd1;
            if (pkt_err_oversize && stat_oversize != '1)
                stat_oversize <= stat_oversize + 32'd1;
            if (pkt_err_timeout && stat_timeout != '1)
                stat_timeout <= stat_timeout + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_axis_depacketize.sv
// tb_axis_depacketize
//   Directed scoreboard bench for axis_depacketize (DATA_WIDTH=8, PKT_SIZE=4,
//   MAX_CLK_CYCLES_PER_PKT=10). Stimulus pushes expected beats and packet
//   reports into queues; a negedge monitor pops and compares them.

module tb_axis_depacketize;

    logic       clk = 1'b0;
    logic       arstn = 1'b0;
    logic [7:0] s_tdata = '0;
    logic       s_tvalid = 1'b0;
    logic       s_tready;
    logic       s_tlast = 1'b0;
    logic [7:0] m_tdata;
    logic       m_tvalid;
    logic       m_tready = 1'b1;
    logic       m_tfirst;
    logic       m_tlast;
    logic       pkt_done;
    logic [2:0] pkt_len;
    logic       pkt_err_oversize;
    logic       pkt_err_timeout;
`ifdef AXIS_DEPKT_STATS_EN
    logic [31:0] stat_pkts, stat_oversize, stat_timeout;
`endif

    always #5 clk = ~clk;

    axis_depacketize #(
        .DATA_WIDTH(8),
        .PKT_SIZE(4),
        .MAX_CLK_CYCLES_PER_PKT(10)
    ) dut (
        .clk(clk),
        .arstn(arstn),
        .s_tdata(s_tdata),
        .s_tvalid(s_tvalid),
        .s_tready(s_tready),
        .s_tlast(s_tlast),
        .m_tdata(m_tdata),
        .m_tvalid(m_tvalid),
        .m_tready(m_tready),
        .m_tfirst(m_tfirst),
        .m_tlast(m_tlast),
        .pkt_done(pkt_done),
        .pkt_len(pkt_len),
        .pkt_err_oversize(pkt_err_oversize),
        .pkt_err_timeout(pkt_err_timeout)
`ifdef AXIS_DEPKT_STATS_EN
        ,
        .stat_pkts(stat_pkts),
        .stat_oversize(stat_oversize),
        .stat_timeout(stat_timeout)
`endif
    );

    typedef struct packed {
        logic [7:0] d;
        logic       f;
        logic       l;
    } beat_t;

    typedef struct packed {
        logic [2:0] len;
        logic       ov;
        logic       to;
    } pkt_t;

    beat_t exp_beats[$];
    pkt_t  exp_pkts[$];
    int    checks = 0;
    int    passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push_pkt(input logic [2:0] len, input logic ov, input logic to);
        pkt_t p;
        p.len = len; p.ov = ov; p.to = to;
        exp_pkts.push_back(p);
    endtask

    // Drive one beat and return once it has been accepted (1 time unit
    // after the accepting edge). waits = cycles spent with s_tready low.
    task automatic send(input logic [7:0] d, input logic last,
                        input logic ef, input logic el, output int waits);
        beat_t b;
        b.d = d; b.f = ef; b.l = el;
        exp_beats.push_back(b);
        s_tdata  = d;
        s_tlast  = last;
        s_tvalid = 1'b1;
        waits    = 0;
        forever begin
            @(negedge clk);
            if (s_tready) break;
            waits++;
            if (waits > 50) begin
                checks++;
                $display("FAIL send_wait: beat %0h not accepted in 50 cycles", d);
                break;
            end
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_beats.size() != 0 || exp_pkts.size() != 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        check("beats_drained", exp_beats.size(), 0);
        check("pkts_drained", exp_pkts.size(), 0);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (arstn) begin
            if (m_tvalid && m_tready) begin
                if (exp_beats.size() == 0) begin
                    checks++;
                    $display("FAIL beat_extra: got data %0h first %0b last %0b, expected no beat",
                             m_tdata, m_tfirst, m_tlast);
                end else begin
                    beat_t b;
                    b = exp_beats.pop_front();
                    check("beat{data,first,last}", {m_tdata, m_tfirst, m_tlast}, {b.d, b.f, b.l});
                end
            end
            if (pkt_done) begin
                if (exp_pkts.size() == 0) begin
                    checks++;
                    $display("FAIL pkt_extra: got len %0d ov %0b to %0b, expected no pkt_done",
                             pkt_len, pkt_err_oversize, pkt_err_timeout);
                end else begin
                    pkt_t p;
                    p = exp_pkts.pop_front();
                    check("pkt{len,ov,to}", {pkt_len, pkt_err_oversize, pkt_err_timeout},
                          {p.len, p.ov, p.to});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int w, w3, w4, n;

        #12;
        check("reset_outputs", {m_tvalid, m_tfirst, m_tlast, pkt_done, pkt_len,
                                pkt_err_oversize, pkt_err_timeout, m_tdata}, 0);
        check("reset_s_tready", s_tready, 1);
        @(posedge clk);
        #1;
        arstn = 1'b1;

        // Normal 3-beat packet
        push_pkt(3'd3, 1'b0, 1'b0);
        send(8'h11, 1'b0, 1'b1, 1'b0, w);
        send(8'h22, 1'b0, 1'b0, 1'b0, w);
        send(8'h33, 1'b1, 1'b0, 1'b1, w);

        // Oversize: 4 beats without tlast, fifth opens a new packet that times out
        push_pkt(3'd4, 1'b1, 1'b0);
        send(8'h01, 1'b0, 1'b1, 1'b0, w);
        send(8'h02, 1'b0, 1'b0, 1'b0, w);
        send(8'h03, 1'b0, 1'b0, 1'b0, w);
        send(8'h04, 1'b0, 1'b0, 1'b1, w);
        push_pkt(3'd1, 1'b0, 1'b1);
        send(8'h05, 1'b0, 1'b1, 1'b0, w);
        n = 0;
        while (n < 30) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (pkt_done) break;
        end
        check("timeout_latency", n, 9);
        @(posedge clk);
        #1;

        // Timeout cycle coincides with an accepted beat: forced last
        push_pkt(3'd2, 1'b0, 1'b1);
        send(8'hA1, 1'b0, 1'b1, 1'b0, w);
        repeat (8) @(posedge clk);
        #1;
        send(8'hA2, 1'b0, 1'b0, 1'b1, w);

        // Backpressure mid-packet
        push_pkt(3'd4, 1'b0, 1'b0);
        send(8'hB1, 1'b0, 1'b1, 1'b0, w);
        send(8'hB2, 1'b0, 1'b0, 1'b0, w);
        m_tready = 1'b0;
        fork
            send(8'hB3, 1'b0, 1'b0, 1'b0, w3);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("stall_s_tready", s_tready, 0);
                    check("stall_m_tdata", m_tdata, 8'hB2);
                end
                @(posedge clk);
                #1;
                m_tready = 1'b1;
            end
        join
        send(8'hB4, 1'b1, 1'b0, 1'b1, w4);
        check("throughput_after_stall", w4, 0);

        // Single-beat packet
        push_pkt(3'd1, 1'b0, 1'b0);
        send(8'h5A, 1'b1, 1'b1, 1'b1, w);
        drain();

`ifdef AXIS_DEPKT_STATS_EN
        check("stat_pkts", stat_pkts, 6);
        check("stat_oversize", stat_oversize, 1);
        check("stat_timeout", stat_timeout, 2);
`endif

        // Reset mid-packet discards the partial packet
        send(8'h77, 1'b0, 1'b1, 1'b0, w);
        @(negedge clk);
        #2;
        arstn = 1'b0;
        #1;
        check("midpkt_reset_outputs", {m_tvalid, m_tfirst, m_tlast, pkt_done, pkt_len,
                                       pkt_err_oversize, pkt_err_timeout, m_tdata}, 0);
`ifdef AXIS_DEPKT_STATS_EN
        check("midpkt_reset_stats", stat_pkts | stat_oversize | stat_timeout, 0);
`endif
        @(posedge clk);
        #1;
        arstn = 1'b1;
        push_pkt(3'd1, 1'b0, 1'b0);
        send(8'h88, 1'b1, 1'b1, 1'b1, w);
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/axis_depacketize.md
Name: axis_depacketize

Overview:
Receive-side counterpart to the AXI-Stream packetizer that frames outbound streams with tlast.
- Consumes a framed AXI-Stream and passes beats through a one-stage register slice.
- Tags each output beat with first/last.
- Polices packet framing against the same beat and cycle limits the packetizer enforces.
- Reports per-packet length and error status to the network input logic.

Parameters:
DATA_WIDTH, 8, tdata width in bits
PKT_SIZE, 4, maximum beats per packet; beat PKT_SIZE without tlast is an oversize error
MAX_CLK_CYCLES_PER_PKT, 10, maximum clock cycles from first beat to closing; exceeding it is a timeout error

Ports:
clk  input  1  clock, all logic on rising edge
arstn  input  1  asynchronous active-low reset
s_tdata  input  DATA_WIDTH  upstream data
s_tvalid  input  1  upstream valid
s_tready  output  1  upstream ready
s_tlast  input  1  upstream end-of-packet
m_tdata  output  DATA_WIDTH  registered data
m_tvalid  output  1  downstream valid
m_tready  input  1  downstream ready
m_tfirst  output  1  beat is first of packet
m_tlast  output  1  beat closes packet (input tlast or forced close)
pkt_done  output  1  one-cycle pulse: packet closed
pkt_len  output  $clog2(PKT_SIZE+1)  beats in closed packet, valid with pkt_done
pkt_err_oversize  output  1  closed packet hit PKT_SIZE without tlast, valid with pkt_done
pkt_err_timeout  output  1  closed packet hit cycle limit, valid with pkt_done

Behaviour:
- Reset (arstn=0, asynchronous):
  - m_tvalid, m_tfirst, m_tlast, pkt_done, both error flags = 0.
  - pkt_len = 0, m_tdata = 0.
  - State IDLE, beat_cnt = 0, clk_cnt = 1.
  - Reset mid-packet discards the partial packet; no pkt_done is issued.
- Handshake and latency:
  - s_tready = !m_tvalid | m_tready (combinational).
  - Accept = s_tvalid & s_tready.
  - An accepted beat appears on m_* the next cycle (latency 1).
  - m_* hold stable while m_tvalid & !m_tready.
  - Full throughput: 1 beat/cycle when m_tready=1.
- States:
  - IDLE: an accepted beat sets m_tfirst=1, beat_cnt=1, clk_cnt=1, and moves to IN_PKT, unless the beat also closes the packet, in which case the state stays IDLE.
  - IN_PKT: every accept increments beat_cnt. clk_cnt increments every cycle while below MAX_CLK_CYCLES_PER_PKT-1.
- Close conditions (evaluated on the current beat or cycle, in priority order):
  1. Accepted beat with s_tlast=1 closes normally.
  2. Accepted beat that brings beat_cnt to PKT_SIZE with s_tlast=0 closes with m_tlast forced 1 and oversize=1.
  3. clk_cnt == MAX_CLK_CYCLES_PER_PKT-1 in IN_PKT closes with timeout=1.
     - If a beat is accepted that cycle, it is the final beat and m_tlast is forced 1.
     - If no beat is accepted, no beat is emitted; the last emitted beat keeps m_tlast=0.
- Simultaneous close conditions: all applicable flags are set together (for example, tlast on the timeout cycle gives a normal close with timeout=1).
- On close:
  - pkt_done pulses for exactly 1 cycle, in the cycle the final beat first presents on m_* (or the cycle after a beatless timeout).
  - pkt_len = beat_cnt including the final beat; pkt_len is never 0.
  - State returns to IDLE, beat_cnt=0, clk_cnt=1.
- A single-beat packet (s_tlast=1 in IDLE) produces m_tfirst=1, m_tlast=1, pkt_len=1.
- Backpressure does not pause clk_cnt: a stall can cause a timeout.

Optional Feature:
AXIS_DEPKT_STATS_EN
- Defined: adds outputs stat_pkts, stat_oversize, stat_timeout (32 bits each).
  - Each counter increments on pkt_done (error counters also gated by their flag).
  - Counters saturate at all-ones and reset to 0 on arstn.
- Undefined: those ports and counters are absent; all other behaviour is identical.

Test Plan:
- PKT_SIZE=4. Send beats 0x11,0x22,0x33 with tlast on 0x33, m_tready=1 → m_tfirst on 0x11, m_tlast on 0x33, pkt_done once, pkt_len=3, no errors.
- Send 5 beats, tlast never asserted → beat 4 has m_tlast=1, pkt_len=4, oversize=1; beat 5 has m_tfirst=1.
- MAX=10. Send 1 beat, then s_tvalid=0 → pkt_done with timeout=1, pkt_len=1, 9 cycles after acceptance; no extra m beat.
- Hold m_tready=0 for 3 cycles mid-packet → s_tready=0, m_tdata stable, no beat lost or duplicated; throughput returns to 1/cycle after release.
- Single beat with tlast in IDLE → m_tfirst=m_tlast=1, pkt_len=1; drop arstn mid-packet → all outputs 0 at once, next beat gives m_tfirst=1.
- With AXIS_DEPKT_STATS_EN: 3 good packets, 1 oversize, 1 timeout → stat_pkts=5, stat_oversize=1, stat_timeout=1.
